round_sat_pipe: RTL

- Pipelined, parametrised successor to the combinational rounding/overflow arithmetic handler.
- Converts a wide signed fixed-point accumulator word (CIC/FIR output) to a narrow signed output word.
- Adds the following on top of the handler:
  - runtime rounding-mode selection
  - runtime power-of-two scale shift
  - valid/ready backpressure
  - saturating overflow/underflow event counters with sticky status
- Sits between a filter stage output and the next stage's input, or the output port.

---
 rtl/round_sat_pipe_pkg.sv | 22 ++
 rtl/round_sat_pipe_sat_event_counter.sv | 48 ++++
 rtl/round_sat_pipe.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/round_sat_pipe_pkg.sv
// Shared types and saturation-bound helpers for the round/saturate pipeline.
package round_sat_pkg;

  typedef enum logic [1:0] {
    RND_TRUNC   = 2'd0,
    RND_HALF_UP = 2'd1,
    RND_CONV    = 2'd2,
    RND_RSVD    = 2'd3
  } round_mode_e;

  // Bounds are returned at 64 bits so callers can slice them to any width below that.
  localparam int unsigned BOUND_W = 64;

  function automatic logic signed [BOUND_W-1:0] out_max(input int unsigned width);
    return (64'sd1 <<< (width - 32'd1)) - 64'sd1;
  endfunction

  function automatic logic signed [BOUND_W-1:0] out_min(input int unsigned width);
    return -(64'sd1 <<< (width - 32'd1));
  endfunction

endpackage

// File: rtl/round_sat_pipe_sat_event_counter.sv
// Saturating event counter: clear wins over hold, but an event in the clear cycle is kept.
module sat_event_counter
  import round_sat_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      if (inc) begin
        cnt_d = CNT_ONE;
      end else begin
        cnt_d = CNT_ZERO;
      end
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/round_sat_pipe.sv
// Two-stage scale/round/saturate pipeline from a wide signed accumulator to a narrow
// signed word, with valid/ready flow control and overflow/underflow statistics.
module round_sat_pipe
  import round_sat_pkg::*;
#(
  parameter int ACC_WIDTH = 42,
  parameter int ACC_FRAC  = 32,
  parameter int OUT_WIDTH = 16,
  parameter int OUT_FRAC  = 15,
  parameter int SHIFT_W   = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [ACC_WIDTH-1:0] s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [1:0]                  round_mode,
  input  logic [SHIFT_W-1:0]          shift,
  output logic signed [OUT_WIDTH-1:0] m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic                        m_ovf,
  output logic                        m_unf,
  input  logic                        clr_stats,
  output logic [CNT_WIDTH-1:0]        ovf_cnt,
  output logic [CNT_WIDTH-1:0]        unf_cnt,
  output logic                        sat_sticky
);

  localparam int FD      = ACC_FRAC - OUT_FRAC;
  localparam int FD_SAFE = (FD < 0) ? 0 : FD;

  localparam logic signed [BOUND_W-1:0]   MAX64   = out_max(OUT_WIDTH);
  localparam logic signed [BOUND_W-1:0]   MIN64   = out_min(OUT_WIDTH);
  localparam logic signed [ACC_WIDTH:0]   MAX_EXT = MAX64[ACC_WIDTH:0];
  localparam logic signed [ACC_WIDTH:0]   MIN_EXT = MIN64[ACC_WIDTH:0];
  localparam logic signed [OUT_WIDTH-1:0] MAX_OUT = MAX64[OUT_WIDTH-1:0];
  localparam logic signed [OUT_WIDTH-1:0] MIN_OUT = MIN64[OUT_WIDTH-1:0];

  if (FD < 0) begin : g_bad_frac
    $error("round_sat_pipe: ACC_FRAC must be >= OUT_FRAC");
  end
  if ((OUT_WIDTH > ACC_WIDTH) || (ACC_WIDTH >= BOUND_W)) begin : g_bad_width
    $error("round_sat_pipe: need OUT_WIDTH <= ACC_WIDTH < 64");
  end

  logic adv1_s, adv2_s;

  logic                        v1_q, v1_d;
  logic signed [ACC_WIDTH-1:0] raw1_q, raw1_d;
  logic                        guard1_q, guard1_d;
  logic                        sticky1_q, sticky1_d;
  round_mode_e                 mode1_q, mode1_d;

  logic                        v2_q, v2_d;
  logic signed [OUT_WIDTH-1:0] data2_q, data2_d;
  logic                        ovf2_q, ovf2_d;
  logic                        unf2_q, unf2_d;

  logic                        sat_sticky_q, sat_sticky_d;

  logic signed [ACC_WIDTH-1:0] acc_s;
  logic signed [ACC_WIDTH-1:0] raw_s;
  logic                        guard_s;
  logic                        sticky_s;
  logic                        inc_s;
  logic signed [ACC_WIDTH:0]   sum_s;
  logic                        ovf_ev_s;
  logic                        unf_ev_s;

  // Shift amounts past the word width sign-fill, which >>> already does.
  assign acc_s = s_data >>> shift;
  assign raw_s = acc_s >>> FD_SAFE;

  if (FD >= 2) begin : g_fd_wide
    assign guard_s  = acc_s[FD-1];
    assign sticky_s = |acc_s[FD-2:0];
  end else if (FD == 1) begin : g_fd_one
    assign guard_s  = acc_s[0];
    assign sticky_s = 1'b0;
  end else begin : g_fd_zero
    assign guard_s  = 1'b0;
    assign sticky_s = 1'b0;
  end

  // Backpressure: each stage advances when empty or when the stage after it drains.
  always_comb begin
    adv2_s  = !v2_q || m_ready;
    adv1_s  = !v1_q || adv2_s;
    s_ready = adv1_s && !rst;
  end

  // S1 next state: capture the scaled sample, its rounding bits and its mode.
  always_comb begin
    v1_d      = v1_q;
    raw1_d    = raw1_q;
    guard1_d  = guard1_q;
    sticky1_d = sticky1_q;
    mode1_d   = mode1_q;
    if (adv1_s) begin
      v1_d = s_valid;
      if (s_valid) begin
        raw1_d    = raw_s;
        guard1_d  = guard_s;
        sticky1_d = sticky_s;
        mode1_d   = round_mode_e'(round_mode);
      end else begin
        raw1_d    = raw1_q;
        guard1_d  = guard1_q;
        sticky1_d = sticky1_q;
        mode1_d   = mode1_q;
      end
    end else begin
      v1_d = v1_q;
    end
  end

  // Rounding increment; the reserved mode behaves as convergent.
  always_comb begin
    case (mode1_q)
      RND_TRUNC:   inc_s = 1'b0;
      RND_HALF_UP: inc_s = guard1_q;
      RND_CONV:    inc_s = guard1_q && (sticky1_q || raw1_q[0]);
      RND_RSVD:    inc_s = guard1_q && (sticky1_q || raw1_q[0]);
      default:     inc_s = 1'b0;
    endcase
  end

  // One extra bit keeps the rounded sum from wrapping before the range check.
  assign sum_s = $signed({raw1_q[ACC_WIDTH-1], raw1_q}) + $signed({{ACC_WIDTH{1'b0}}, inc_s});

  // S2 next state: saturate the rounded value and flag range violations.
  always_comb begin
    v2_d    = v2_q;
    data2_d = data2_q;
    ovf2_d  = ovf2_q;
    unf2_d  = unf2_q;
    if (adv2_s) begin
      v2_d = v1_q;
      if (v1_q) begin
        if (sum_s > MAX_EXT) begin
          data2_d = MAX_OUT;
          ovf2_d  = 1'b1;
          unf2_d  = 1'b0;
        end else if (sum_s < MIN_EXT) begin
          data2_d = MIN_OUT;
          ovf2_d  = 1'b0;
          unf2_d  = 1'b1;
        end else begin
          data2_d = sum_s[OUT_WIDTH-1:0];
          ovf2_d  = 1'b0;
          unf2_d  = 1'b0;
        end
      end else begin
        data2_d = data2_q;
        ovf2_d  = ovf2_q;
        unf2_d  = unf2_q;
      end
    end else begin
      v2_d = v2_q;
    end
  end

  assign ovf_ev_s = v2_q && m_ready && ovf2_q;
  assign unf_ev_s = v2_q && m_ready && unf2_q;

  // Sticky saturation status; an event coincident with a clear still sets it.
  always_comb begin
    if (clr_stats) begin
      sat_sticky_d = ovf_ev_s || unf_ev_s;
    end else begin
      sat_sticky_d = sat_sticky_q || ovf_ev_s || unf_ev_s;
    end
  end

  // Pipeline and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q         <= 1'b0;
      raw1_q       <= {ACC_WIDTH{1'b0}};
      guard1_q     <= 1'b0;
      sticky1_q    <= 1'b0;
      mode1_q      <= RND_TRUNC;
      v2_q         <= 1'b0;
      data2_q      <= {OUT_WIDTH{1'b0}};
      ovf2_q       <= 1'b0;
      unf2_q       <= 1'b0;
      sat_sticky_q <= 1'b0;
    end else begin
      v1_q         <= v1_d;
      raw1_q       <= raw1_d;
      guard1_q     <= guard1_d;
      sticky1_q    <= sticky1_d;
      mode1_q      <= mode1_d;
      v2_q         <= v2_d;
      data2_q      <= data2_d;
      ovf2_q       <= ovf2_d;
      unf2_q       <= unf2_d;
      sat_sticky_q <= sat_sticky_d;
    end
  end

  sat_event_counter #(.CNT_WIDTH(CNT_WIDTH)) u_ovf_cnt (
    .clk (clk),
    .rst (rst),
    .inc (ovf_ev_s),
    .clr (clr_stats),
    .cnt (ovf_cnt)
  );

  sat_event_counter #(.CNT_WIDTH(CNT_WIDTH)) u_unf_cnt (
    .clk (clk),
    .rst (rst),
    .inc (unf_ev_s),
    .clr (clr_stats),
    .cnt (unf_cnt)
  );

  assign m_valid    = v2_q;
  assign m_data     = data2_q;
  assign m_ovf      = ovf2_q;
  assign m_unf      = unf2_q;
  assign sat_sticky = sat_sticky_q;

endmodule
